// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message-schedule controller:
// round counts, FSM state encoding and the small-sigma helpers used
// to expand the message schedule.
package sha256_pkg;

  localparam int SHA256_ROUNDS     = 64;
  localparam int SHA256_LOAD_WORDS = 16;
  localparam int SHA256_RIDX_W     = $clog2(SHA256_ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_e;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_sched_ctrl_if.sv
// Bundles the message-word input stream and the W[t] output stream of
// the schedule controller. The slave view belongs to the controller,
// the master view to whatever sources words and sinks W[t].
interface sha256_sched_ctrl_if
  import sha256_pkg::*;
#(
  parameter int RIDX_W = SHA256_RIDX_W
);

  logic [31:0]       s_dat_i;
  logic              s_vaild_i;
  logic              s_last_i;
  logic              s_ready_o;
  logic [31:0]       w_o;
  logic              w_vaild_o;
  logic              w_ready_i;
  logic [RIDX_W-1:0] round_idx_o;
  logic              chunk_first_o;

  modport slave (
    input  s_dat_i, s_vaild_i, s_last_i, w_ready_i,
    output s_ready_o, w_o, w_vaild_o, round_idx_o, chunk_first_o
  );

  modport master (
    output s_dat_i, s_vaild_i, s_last_i, w_ready_i,
    input  s_ready_o, w_o, w_vaild_o, round_idx_o, chunk_first_o
  );

endinterface

// File: rtl/sha256_chunk_process.sv
// SHA-256 message-schedule window. Holds the last 16 W values; each
// strobe shifts one new word in, either a loaded message word or the
// expanded word sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16].
// Without a strobe the window holds, which is how a stall is absorbed.
module sha256_chunk_process
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dat_msb_i,
  input  logic        dat_vaild_i,
  input  logic        load_sel_i,
  input  logic        process_start,
  output logic [31:0] w_out
);

  // win_q[0] is W[t-16], win_q[15] is W[t-1]
  logic [31:0] win_q [SHA256_LOAD_WORDS];
  logic [31:0] expandWord;
  logic        shiftEn;

  assign expandWord = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
  assign w_out      = load_sel_i ? dat_msb_i : expandWord;
  assign shiftEn    = dat_vaild_i | process_start;

  // Shift the presented word into the window on every strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SHA256_LOAD_WORDS; i++) begin
        win_q[i] <= '0;
      end
    end else if (shiftEn) begin
      for (int i = 0; i < SHA256_LOAD_WORDS - 1; i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[SHA256_LOAD_WORDS-1] <= w_out;
    end
  end

endmodule

// File: rtl/sha256_sched_ctrl.sv
// Sequences one 512-bit chunk through the message schedule: 16 words
// are streamed in as rounds 0..15, then the schedule is strobed for
// rounds 16..63. Every W[t] is offered to the compression core, which
// may stall; the round counter and the schedule only move on a
// transfer. Also tracks first/last chunk and flags misplaced s_last_i.
// The schedule's w_out is brought out as the sched_w_o debug tap.
module sha256_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS     = SHA256_ROUNDS,
  parameter int LOAD_WORDS = SHA256_LOAD_WORDS,
  parameter int RIDX_W     = SHA256_RIDX_W
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic                      abort_i,
  sha256_sched_ctrl_if.slave        bus,
  output logic [31:0]               sched_dat_o,
  output logic                      sched_vaild_o,
  output logic                      sched_start_o,
  output logic [31:0]               sched_w_o,
  output logic                      chunk_done_o,
  output logic                      msg_last_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam logic [RIDX_W-1:0] LastLoadIdx    = RIDX_W'(LOAD_WORDS - 1);
  localparam logic [RIDX_W-1:0] FirstExpandIdx = RIDX_W'(LOAD_WORDS);
  localparam logic [RIDX_W-1:0] LastRoundIdx   = RIDX_W'(ROUNDS - 1);

  sched_state_e      state_q, state_d;
  logic [RIDX_W-1:0] round_q, round_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              inLoad, inExpand, wXfer;
  logic [31:0]       schedW;

  assign inLoad   = (state_q == ST_LOAD);
  assign inExpand = (state_q == ST_EXPAND);
  assign wXfer    = bus.w_vaild_o && bus.w_ready_i;

  // The load path goes straight from s_dat_i so a loaded word reaches
  // w_o in the same cycle it is offered.
  sha256_chunk_process u_sched (
    .clk           (clk),
    .rst           (rst),
    .dat_msb_i     (bus.s_dat_i),
    .dat_vaild_i   (sched_vaild_o),
    .load_sel_i    (inLoad),
    .process_start (sched_start_o),
    .w_out         (schedW)
  );

  assign sched_w_o = schedW;
  assign bus.w_o   = (inLoad || inExpand) ? schedW : '0;

  // State, round counter and chunk flags register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      first_q <= first_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next state: advance only on W transfers; abort overrides everything
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    first_d = first_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        round_d = '0;
        if (en_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (wXfer) begin
          if (round_q == LastLoadIdx) begin
            last_d  = bus.s_last_i;
            round_d = FirstExpandIdx;
            state_d = ST_EXPAND;
          end else begin
            round_d = round_q + RIDX_W'(1);
            if (bus.s_last_i) err_d = 1'b1;
          end
        end
      end
      ST_EXPAND: begin
        if (wXfer) begin
          if (round_q == LastRoundIdx) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_q + RIDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = en_i ? ST_LOAD : ST_IDLE;
        round_d = '0;
        first_d = last_q;
        last_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      round_d = '0;
      first_d = 1'b1;
      last_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  // Outputs: stream handshakes and schedule strobes gated by w_ready_i
  always_comb begin
    bus.s_ready_o = 1'b0;
    bus.w_vaild_o = 1'b0;
    sched_dat_o   = '0;
    sched_vaild_o = 1'b0;
    sched_start_o = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        bus.s_ready_o = bus.w_ready_i;
        bus.w_vaild_o = bus.s_vaild_i;
        sched_dat_o   = bus.s_dat_i;
        sched_vaild_o = bus.s_vaild_i && bus.w_ready_i;
      end
      ST_EXPAND: begin
        bus.w_vaild_o = 1'b1;
        sched_start_o = bus.w_ready_i;
      end
      default: begin
      end
    endcase
    bus.round_idx_o   = round_q;
    bus.chunk_first_o = first_q && (inLoad || inExpand);
    chunk_done_o      = (state_q == ST_DONE);
    msg_last_o        = (state_q == ST_DONE) && last_q;
    busy_o            = (state_q != ST_IDLE);
    err_o             = err_q;
  end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Self-checking bench for sha256_sched_ctrl. Expected W values come
// from a plain-arithmetic SHA-256 schedule; flags come from a small
// message-level model (first chunk, last chunk, sticky error).
module tb_sha256_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst, en_i, abort_i;
  logic [31:0] schedDat, schedW;
  logic        schedVaild, schedStart;
  logic        chunkDone, msgLast, busy, err;

  sha256_sched_ctrl_if bus();

  sha256_sched_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en_i),
    .abort_i       (abort_i),
    .bus           (bus),
    .sched_dat_o   (schedDat),
    .sched_vaild_o (schedVaild),
    .sched_start_o (schedStart),
    .sched_w_o     (schedW),
    .chunk_done_o  (chunkDone),
    .msg_last_o    (msgLast),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int          errCount = 0;
  int          checkCount = 0;
  logic [31:0] msgWords [16];
  logic [31:0] refW [64];
  logic [31:0] gotW [64];
  bit          modelFirst;
  bit          modelErr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule straight from the SHA-256 definition
  task automatic buildRef();
    for (int t = 0; t < 16; t++) refW[t] = msgWords[t];
    for (int t = 16; t < 64; t++) begin
      refW[t] = (rotr(refW[t-2], 17) ^ rotr(refW[t-2], 19) ^ (refW[t-2] >> 10))
              + refW[t-7]
              + (rotr(refW[t-15], 7) ^ rotr(refW[t-15], 18) ^ (refW[t-15] >> 3))
              + refW[t-16];
    end
  endtask

  task automatic loadAbc();
    for (int i = 0; i < 16; i++) msgWords[i] = 32'h0;
    msgWords[0]  = 32'h61626380;
    msgWords[15] = 32'h00000018;
    buildRef();
  endtask

  task automatic loadRandom();
    for (int i = 0; i < 16; i++) msgWords[i] = $urandom;
    buildRef();
  endtask

  task automatic idleInputs();
    bus.s_dat_i   = '0;
    bus.s_vaild_i = 1'b0;
    bus.s_last_i  = 1'b0;
    bus.w_ready_i = 1'b0;
  endtask

  task automatic startFromIdle();
    @(negedge clk);
    en_i = 1'b1;
  endtask

  task automatic pulseAbort();
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    checkOutput("abort_err_clr", err, 0);
    checkOutput("abort_busy", busy, 0);
    modelErr   = 1'b0;
    modelFirst = 1'b1;
  endtask

  // Drive one chunk. stallMode: 0 ready held, 1 low every third cycle,
  // 2 random. abortAt/resetAt fire when the round index reaches them.
  task automatic applyStimulus(input logic [15:0] lastMask, input int stallMode, input bit gaps,
                               input bit nextEn, input int abortAt, input int resetAt,
                               output int cycles);
    int k;
    int cyc;
    bit wr, sv, xfer;
    k = 0;
    cyc = 0;
    cycles = 0;
    while (k < 64 && cyc < 1000) begin
      @(negedge clk);
      en_i = 1'b0;
      case (stallMode)
        0:       wr = 1'b1;
        1:       wr = (cyc % 3) != 2;
        default: wr = $urandom_range(0, 3) != 0;
      endcase
      if (k < 16) begin
        sv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.s_dat_i  = msgWords[k];
        bus.s_last_i = lastMask[k];
      end else begin
        sv = 1'($urandom_range(0, 1));
        bus.s_dat_i  = $urandom;
        bus.s_last_i = 1'($urandom_range(0, 1));
      end
      bus.s_vaild_i = sv;
      bus.w_ready_i = wr;
      abort_i = (k == abortAt);
      if (k == resetAt) rst = 1'b1;
      #1;
      if (k == resetAt) begin
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", chunkDone, 0);
        checkOutput("rst_wvalid", bus.w_vaild_o, 0);
        @(negedge clk);
        rst = 1'b0;
        idleInputs();
        modelFirst = 1'b1;
        modelErr   = 1'b0;
        cycles = cyc;
        return;
      end
      xfer = (k < 16) ? (sv && wr) : wr;
      checkOutput("wvalid", bus.w_vaild_o, (k < 16) ? sv : 1'b1);
      checkOutput("sready", bus.s_ready_o, (k < 16) ? wr : 1'b0);
      checkOutput("sched_vaild", schedVaild, (k < 16) && xfer);
      checkOutput("sched_start", schedStart, (k >= 16) && xfer);
      checkOutput("sched_dat", schedDat, (k < 16) ? msgWords[k] : 32'h0);
      checkOutput("done_early", chunkDone, 0);
      checkOutput("busy", busy, 1);
      checkOutput("err_sticky", err, modelErr);
      if (xfer) begin
        gotW[k] = bus.w_o;
        checkOutput($sformatf("w%0d", k), bus.w_o, refW[k]);
        checkOutput("wtap", schedW, refW[k]);
        checkOutput("ridx", bus.round_idx_o, k);
        checkOutput("first", bus.chunk_first_o, modelFirst);
        if (k < 15 && lastMask[k]) modelErr = 1'b1;
      end
      if (k == abortAt) begin
        @(negedge clk);
        abort_i = 1'b0;
        idleInputs();
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", chunkDone, 0);
        checkOutput("abort_err", err, 0);
        modelFirst = 1'b1;
        modelErr   = 1'b0;
        cycles = cyc;
        return;
      end
      if (xfer) k++;
      cyc++;
    end
    cycles = cyc;
    if (k < 64) begin
      checkOutput("timeout", k, 64);
      return;
    end
    @(negedge clk);
    idleInputs();
    en_i = nextEn;
    #1;
    checkOutput("done", chunkDone, 1);
    checkOutput("msg_last", msgLast, lastMask[15]);
    checkOutput("err_done", err, modelErr);
    checkOutput("wvalid_done", bus.w_vaild_o, 0);
    checkOutput("sready_done", bus.s_ready_o, 0);
    modelFirst = lastMask[15];
    if (!nextEn) begin
      @(negedge clk);
      #1;
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_sready", bus.s_ready_o, 0);
      checkOutput("idle_done", chunkDone, 0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int nCh;
    int bitIdx;
    logic [15:0] mask;

    rst = 1'b1;
    en_i = 1'b0;
    abort_i = 1'b0;
    idleInputs();
    modelFirst = 1'b1;
    modelErr   = 1'b0;
    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sready", bus.s_ready_o, 0);
    checkOutput("reset_wvalid", bus.w_vaild_o, 0);
    checkOutput("reset_w", bus.w_o, 0);
    checkOutput("reset_ridx", bus.round_idx_o, 0);
    checkOutput("reset_first", bus.chunk_first_o, 0);
    checkOutput("reset_done", chunkDone, 0);
    checkOutput("reset_last", msgLast, 0);
    checkOutput("reset_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] abc single chunk");
    loadAbc();
    startFromIdle();
    applyStimulus(16'h8000, 0, 1'b0, 1'b0, -1, -1, cyc);
    checkOutput("abc_latency", cyc, 64);
    checkOutput("abc_w16", gotW[16], 32'h61626380);
    checkOutput("abc_w17", gotW[17], 32'h000F0000);

    $display("[TB] back-pressure every third cycle");
    startFromIdle();
    applyStimulus(16'h8000, 1, 1'b0, 1'b0, -1, -1, cyc);

    $display("[TB] two-chunk message");
    loadRandom();
    startFromIdle();
    applyStimulus(16'h0000, 2, 1'b0, 1'b1, -1, -1, cyc);
    loadRandom();
    applyStimulus(16'h8000, 2, 1'b0, 1'b0, -1, -1, cyc);

    $display("[TB] input gaps");
    loadAbc();
    startFromIdle();
    applyStimulus(16'h8000, 0, 1'b1, 1'b0, -1, -1, cyc);

    $display("[TB] misplaced last on word 7");
    loadRandom();
    startFromIdle();
    applyStimulus(16'h0080, 0, 1'b1, 1'b0, -1, -1, cyc);
    checkOutput("err_idle_sticky", err, 1);
    pulseAbort();

    $display("[TB] abort at t=30 then reset at t=40");
    loadAbc();
    startFromIdle();
    applyStimulus(16'h8000, 0, 1'b0, 1'b0, 30, -1, cyc);
    startFromIdle();
    applyStimulus(16'h8000, 0, 1'b0, 1'b0, -1, 40, cyc);
    startFromIdle();
    applyStimulus(16'h8000, 0, 1'b0, 1'b0, -1, -1, cyc);
    checkOutput("post_rst_w16", gotW[16], 32'h61626380);
    checkOutput("post_rst_w17", gotW[17], 32'h000F0000);

    $display("[TB] randomized messages");
    for (int m = 0; m < 6; m++) begin
      nCh = $urandom_range(1, 3);
      startFromIdle();
      for (int c = 0; c < nCh; c++) begin
        loadRandom();
        mask = (c == nCh - 1) ? 16'h8000 : 16'h0000;
        if ($urandom_range(0, 3) == 0) begin
          bitIdx = $urandom_range(0, 14);
          mask[bitIdx] = 1'b1;
        end
        applyStimulus(mask, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      c < nCh - 1, -1, -1, cyc);
      end
      if ($urandom_range(0, 1) == 1) pulseAbort();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
